// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer for the CPU core.
// It produces the 2-bit cycle code for the decoder and inserts stalls for memory wait states,
// multiplier wait, interrupt entry and halt/resume. It also keeps a retired-instruction counter.
module cpu_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MUL_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sm_extra,
  input  logic             stop,
  input  logic             mul_start,
  input  logic             mul_done,
  input  logic             mem_ready,
  input  logic             irq_req,
  input  logic             irq_en,
  input  logic             run,
  output logic [1:0]       state,
  output logic             idle,
  output logic             ir_load,
  output logic             irq_ack,
  output logic             irq_vec_load,
  output logic             halted,
  output logic             mul_timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned MulCntW = $clog2(MUL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StFetch,
    StExec1,
    StExec2,
    StMulWait,
    StIrq,
    StHalt
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [1:0]         state_q, state_d;
  logic               halted_q, halted_d;
  logic               irq_ack_q, irq_ack_d;
  logic               irq_pending_q, irq_pending_d;
  logic               irq_req_q;
  logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               mul_err_q, mul_err_d;
  logic               eoi;

  // Next-state logic: cycle sequencing, retirement counting and the timeout flag.
  always_comb begin
    fsm_d         = fsm_q;
    mul_cnt_d     = mul_cnt_q;
    instr_count_d = instr_count_q;
    mul_err_d     = mul_err_q;
    eoi           = 1'b0;

    unique case (fsm_q)
      StFetch: begin
        if (mem_ready) fsm_d = StExec1;
      end
      // Exec1 is never stalled, so decoder side-effects happen exactly once.
      StExec1: begin
        if (stop) begin
          fsm_d         = StHalt;
          instr_count_d = instr_count_q + CNT_W'(1);
        end else if (mul_start) begin
          fsm_d     = StMulWait;
          mul_cnt_d = '0;
        end else if (sm_extra) begin
          fsm_d = StExec2;
        end else begin
          eoi = 1'b1;
        end
      end
      StExec2: begin
        if (mem_ready) eoi = 1'b1;
      end
      // mul_done takes priority over a timeout in the same cycle.
      StMulWait: begin
        mul_cnt_d = mul_cnt_q + MulCntW'(1);
        if (mul_done) begin
          eoi = 1'b1;
        end else if (mul_cnt_q == MulCntW'(MUL_TIMEOUT - 1)) begin
          fsm_d     = StHalt;
          mul_err_d = 1'b1;
        end
      end
      StIrq: begin
        fsm_d = StFetch;
      end
      StHalt: begin
        if (run) begin
          fsm_d     = StFetch;
          mul_err_d = 1'b0;
        end
      end
      default: begin
        fsm_d = StFetch;
      end
    endcase

    if (eoi) begin
      instr_count_d = instr_count_q + CNT_W'(1);
      fsm_d         = (irq_pending_q && irq_en) ? StIrq : StFetch;
    end
  end

  // A new request edge wins over the clear applied while in the IRQ state.
  always_comb begin
    irq_pending_d = (irq_req & ~irq_req_q) | (irq_pending_q & (fsm_q != StIrq));
  end

  // Registered Moore outputs are decoded from the next state.
  always_comb begin
    unique case (fsm_d)
      StFetch: state_d = 2'b00;
      StExec1: state_d = 2'b01;
      StExec2: state_d = 2'b10;
      default: state_d = 2'b11;
    endcase
    halted_d  = (fsm_d == StHalt);
    irq_ack_d = (fsm_d == StIrq);
  end

  // State and output registers with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= StFetch;
      state_q       <= 2'b00;
      halted_q      <= 1'b0;
      irq_ack_q     <= 1'b0;
      irq_pending_q <= 1'b0;
      irq_req_q     <= 1'b0;
      mul_cnt_q     <= '0;
      instr_count_q <= '0;
      mul_err_q     <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      halted_q      <= halted_d;
      irq_ack_q     <= irq_ack_d;
      irq_pending_q <= irq_pending_d;
      irq_req_q     <= irq_req;
      mul_cnt_q     <= mul_cnt_d;
      instr_count_q <= instr_count_d;
      mul_err_q     <= mul_err_d;
    end
  end

  // Output wiring; ir_load is the only Mealy output.
  always_comb begin
    state           = state_q;
    idle            = (state_q == 2'b11);
    ir_load         = (fsm_q == StFetch) & mem_ready;
    irq_ack         = irq_ack_q;
    irq_vec_load    = irq_ack_q;
    halted          = halted_q;
    mul_timeout_err = mul_err_q;
    instr_count     = instr_count_q;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; expectations are queued per step and checked at negedge.
module tb_cpu_sequencer;

  // Narrow counter so that wraparound is reachable in a short run.
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sm_extra, stop, mul_start, mul_done, mem_ready, irq_req, irq_en, run;
  logic [1:0]    state;
  logic          idle, ir_load, irq_ack, irq_vec_load, halted, mul_timeout_err;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .CNT_W      (CW),
    .MUL_TIMEOUT(15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sm_extra       (sm_extra),
    .stop           (stop),
    .mul_start      (mul_start),
    .mul_done       (mul_done),
    .mem_ready      (mem_ready),
    .irq_req        (irq_req),
    .irq_en         (irq_en),
    .run            (run),
    .state          (state),
    .idle           (idle),
    .ir_load        (ir_load),
    .irq_ack        (irq_ack),
    .irq_vec_load   (irq_vec_load),
    .halted         (halted),
    .mul_timeout_err(mul_timeout_err),
    .instr_count    (instr_count)
  );

  typedef struct packed {
    logic [1:0]    st;
    logic          idle;
    logic          irl;
    logic          ack;
    logic          vec;
    logic          hlt;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    exp_cnt  = 0;
  string tag      = "reset";

  task automatic drv(input logic se, sp, ms, md, mr, ir, ie, rn);
    sm_extra  = se;
    stop      = sp;
    mul_start = ms;
    mul_done  = md;
    mem_ready = mr;
    irq_req   = ir;
    irq_en    = ie;
    run       = rn;
  endtask

  task automatic chk(input string what, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic irl, ack, hlt, err);
    exp_t e;
    e.st   = st;
    e.idle = (st == 2'b11);
    e.irl  = irl;
    e.ack  = ack;
    e.vec  = ack;
    e.hlt  = hlt;
    e.err  = err;
    e.cnt  = exp_cnt[CW-1:0];
    sb.push_back(e);
  endtask

  task automatic cmp_now();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s/scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk("state", 16'(state), 16'(e.st));
    chk("idle", 16'(idle), 16'(e.idle));
    chk("ir_load", 16'(ir_load), 16'(e.irl));
    chk("irq_ack", 16'(irq_ack), 16'(e.ack));
    chk("irq_vec_load", 16'(irq_vec_load), 16'(e.vec));
    chk("halted", 16'(halted), 16'(e.hlt));
    chk("mul_timeout_err", 16'(mul_timeout_err), 16'(e.err));
    chk("instr_count", 16'(instr_count), 16'(e.cnt));
  endtask

  // One clock step: queue expectation, compare at negedge, return just after the next posedge.
  task automatic cyc(input logic [1:0] st, input logic irl, ack, hlt, err);
    push(st, irl, ack, hlt, err);
    @(negedge clk);
    cmp_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Plain ALU instruction.
    tag = "alu";
    drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd1, 0, 0, 0, 0); exp_cnt++;
    cyc(2'd0, 0, 0, 0, 0);

    // Two-cycle instruction with memory wait states in exec2.
    tag = "ldi";
    drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc(2'd1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd2, 0, 0, 0, 0);
    cyc(2'd2, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd2, 0, 0, 0, 0); exp_cnt++;
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd0, 0, 0, 0, 0);

    // Multiply completing on the fourth wait cycle.
    tag = "mul";
    drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 0, 0); cyc(2'd1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(2'd3, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 0, 0); cyc(2'd3, 0, 0, 0, 0); exp_cnt++;
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd0, 0, 0, 0, 0);

    // Multiplier never answers: halt with error after 15 wait cycles, then resume.
    tag = "mul_timeout";
    drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 0, 0); cyc(2'd1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (15) cyc(2'd3, 0, 0, 0, 0);
    cyc(2'd3, 0, 0, 1, 1);
    cyc(2'd3, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1); cyc(2'd3, 0, 0, 1, 1);
    tag = "run_ignored";
    cyc(2'd0, 0, 0, 0, 0);
    cyc(2'd0, 0, 0, 0, 0);

    // Interrupt with irq_en set: taken at the end of the instruction.
    tag = "irq";
    drv(0, 0, 0, 0, 1, 1, 1, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 1, 0); cyc(2'd1, 0, 0, 0, 0); exp_cnt++;
    cyc(2'd3, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0); cyc(2'd0, 0, 0, 0, 0);

    // Interrupt held pending while disabled, taken once enabled.
    tag = "irq_masked";
    drv(0, 0, 0, 0, 1, 1, 0, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 0, 0); cyc(2'd1, 0, 0, 0, 0); exp_cnt++;
    drv(0, 0, 0, 0, 1, 1, 0, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 1, 0); cyc(2'd1, 0, 0, 0, 0); exp_cnt++;
    cyc(2'd3, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd0, 0, 0, 0, 0);

    // stop beats mul_start and a pending interrupt; the interrupt survives halt.
    tag = "stop_irq";
    drv(0, 0, 0, 0, 1, 1, 1, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 1, 1, 0, 0, 1, 1, 0); cyc(2'd1, 0, 0, 0, 0); exp_cnt++;
    drv(0, 0, 0, 0, 0, 1, 1, 0); cyc(2'd3, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 1); cyc(2'd3, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 1, 0, 1, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0); cyc(2'd1, 0, 0, 0, 0); exp_cnt++;
    cyc(2'd3, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd0, 0, 0, 0, 0);

    // mul_done on the very cycle the limit is reached retires normally.
    tag = "mul_limit";
    drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 0, 0); cyc(2'd1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (14) cyc(2'd3, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 0, 0); cyc(2'd3, 0, 0, 0, 0); exp_cnt++;
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd0, 0, 0, 0, 0);

    // Bring the counter to all-ones, then reset in the middle of a multiply.
    tag = "fill";
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd0, 1, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd1, 0, 0, 0, 0); exp_cnt++;
    end
    tag = "reset_mid_mul";
    drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd0, 1, 0, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 0, 0); cyc(2'd1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd3, 0, 0, 0, 0);
    cyc(2'd3, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    exp_cnt = 0;
    push(2'd0, 0, 0, 0, 0);
    cmp_now();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Retire 2^CW instructions from zero: the counter wraps back to zero.
    tag = "wrap";
    for (int i = 0; i < 16; i++) begin
      drv(0, 0, 0, 0, 1, 0, 0, 0); cyc(2'd0, 1, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0); cyc(2'd1, 0, 0, 0, 0); exp_cnt++;
    end
    cyc(2'd0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
